// File: rtl/spi_link_pkg.sv
// Shared definitions for the board-to-board SPI link (master TX and slave RX).
// Optional macro SPI_TX_PARITY_EN appends an even-parity bit to every frame.
`default_nettype none

package spi_link_pkg;

    localparam int DEFAULT_DATA_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int frame_bits(input int data_w);
`ifdef SPI_TX_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/sclk_tick_gen.sv
// Half-period enable generator: half_tick pulses once every CLK_DIV enabled cycles.
`default_nettype none

module sclk_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic half_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] WRAP = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || !en || (cnt == WRAP)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign half_tick = en && (cnt == WRAP);

endmodule

`default_nettype wire

// File: rtl/spi_nibble_master_tx.sv
// SPI mode-0 master transmitter: one DATA_W-bit frame per start, MSB first, cs_n framed.
// Optional macro SPI_TX_PARITY_EN appends an even-parity bit after the LSB.
`default_nettype none

module spi_nibble_master_tx
    import spi_link_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n
);

    localparam int FRAME_BITS = frame_bits(DATA_W);
    localparam int BIT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS + 1) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

    state_t                state, state_next;
    logic [FRAME_BITS-1:0] shreg, shreg_next, shreg_rot, load_value;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_next;
    logic                  sclk_next, mosi_next, cs_n_next, busy_next, done_next;
    logic                  half_tick, tick_en, tick_clear;

`ifdef SPI_TX_PARITY_EN
    assign load_value = {data_in, ^data_in};
`else
    assign load_value = data_in;
`endif

    // Rotate rather than shift so the register stays fully used; the current bit sits at the MSB.
    assign shreg_rot = (shreg << 1) | (shreg >> (FRAME_BITS - 1));

    assign tick_en    = (state == SETUP) || (state == SHIFT) || (state == HOLD);
    assign tick_clear = (state_next != state);

    sclk_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .en        (tick_en),
        .clear     (tick_clear),
        .half_tick (half_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt_next;
            sclk    <= sclk_next;
            mosi    <= mosi_next;
            cs_n    <= cs_n_next;
            busy    <= busy_next;
            done    <= done_next;
        end
    end

    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        sclk_next    = sclk;
        mosi_next    = mosi;
        cs_n_next    = cs_n;
        busy_next    = busy;
        done_next    = done;

        case (state)
            IDLE: begin
                if (start) begin
                    shreg_next   = load_value;
                    bit_cnt_next = '0;
                    cs_n_next    = 1'b0;
                    mosi_next    = data_in[DATA_W-1];
                    busy_next    = 1'b1;
                    state_next   = SETUP;
                end
            end
            SETUP: begin
                if (half_tick) begin
                    sclk_next  = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (half_tick) begin
                    if (sclk) begin
                        // Falling edge: advance to the next bit unless this was the last one.
                        sclk_next = 1'b0;
                        if (bit_cnt != LAST_BIT) begin
                            shreg_next = shreg_rot;
                            mosi_next  = shreg_rot[FRAME_BITS-1];
                        end
                    end else if (bit_cnt == LAST_BIT) begin
                        state_next = HOLD;
                    end else begin
                        sclk_next    = 1'b1;
                        bit_cnt_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (half_tick) begin
                    cs_n_next  = 1'b1;
                    mosi_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done_next  = 1'b0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_nibble_master_tx.sv
// Bench for spi_nibble_master_tx: two instances (CLK_DIV=2 and CLK_DIV=1) against a timing-offset model.
`default_nettype none

module tb_spi_nibble_master_tx;

`ifdef SPI_TX_PARITY_EN
    localparam int FB = 5;
`else
    localparam int FB = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start;
    logic [3:0] din0, din1;
    wire  [1:0] busy, done, sclk, mosi, cs_n;

    always #5 clk = ~clk;

    spi_nibble_master_tx #(.CLK_DIV(2), .DATA_W(4)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .data_in(din0),
        .busy(busy[0]), .done(done[0]), .sclk(sclk[0]), .mosi(mosi[0]), .cs_n(cs_n[0])
    );

    spi_nibble_master_tx #(.CLK_DIV(1), .DATA_W(4)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .data_in(din1),
        .busy(busy[1]), .done(done[1]), .sclk(sclk[1]), .mosi(mosi[1]), .cs_n(cs_n[1])
    );

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         cdiv   [2] = '{2, 1};
    bit         m_act  [2];
    int         m_k    [2];
    logic [7:0] m_bits [2];

    function automatic logic [7:0] frame_of(input logic [3:0] d);
`ifdef SPI_TX_PARITY_EN
        return {3'b000, d, ^d};
`else
        return {4'b0000, d};
`endif
    endfunction

    // Expected {busy, done, sclk, mosi, cs_n} k cycles after the accepting edge.
    function automatic logic [4:0] exp_out(input bit act, input int k, input logic [7:0] bits, input int c);
        int   len;
        int   p;
        int   bi;
        logic s;
        len = c * (2 * FB + 2);
        if (!act) return 5'b00001;
        if (k >= len) return 5'b11001;
        p  = k - c;
        s  = (p >= 0) && (p < 2 * c * FB) && (((p / c) % 2) == 0);
        bi = k / (2 * c);
        if (bi > FB - 1) bi = FB - 1;
        return {1'b1, 1'b0, s, bits[FB-1-bi], 1'b0};
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_act[d] = 1'b0;
            end else if (m_act[d]) begin
                m_k[d]++;
                if (m_k[d] > cdiv[d] * (2 * FB + 2)) m_act[d] = 1'b0;
            end else if (start[d]) begin
                m_act[d]  = 1'b1;
                m_k[d]    = 0;
                m_bits[d] = frame_of(d == 0 ? din0 : din1);
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int d = 0; d < 2; d++) begin
                logic [4:0] e;
                e = exp_out(m_act[d], m_k[d], m_bits[d], cdiv[d]);
                chk($sformatf("u%0d busy", d), {31'd0, busy[d]}, {31'd0, e[4]});
                chk($sformatf("u%0d done", d), {31'd0, done[d]}, {31'd0, e[3]});
                chk($sformatf("u%0d sclk", d), {31'd0, sclk[d]}, {31'd0, e[2]});
                chk($sformatf("u%0d mosi", d), {31'd0, mosi[d]}, {31'd0, e[1]});
                chk($sformatf("u%0d cs_n", d), {31'd0, cs_n[d]}, {31'd0, e[0]});
            end
        end
    end

    // ---------------- frame monitor (pins literal expectations) ----------------
    logic       p_sclk [2] = '{1'b0, 1'b0};
    logic       p_cs   [2] = '{1'b1, 1'b1};
    logic       p_busy [2] = '{1'b0, 1'b0};
    int         low_cnt [2], high_cnt [2], busy_run [2], cur_nb [2];
    logic [7:0] cur_bits [2];
    int         last_len [2], last_nb [2], last_gap [2], last_busy [2], frames [2], dones [2];
    logic [7:0] last_bits [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (done[d] === 1'b1) dones[d]++;
            if (busy[d] === 1'b1) busy_run[d]++;
            else if (p_busy[d] === 1'b1) begin
                last_busy[d] = busy_run[d];
                busy_run[d]  = 0;
            end
            if (cs_n[d] === 1'b0) begin
                if (p_cs[d] === 1'b1) begin
                    last_gap[d] = high_cnt[d];
                    high_cnt[d] = 0;
                    low_cnt[d]  = 0;
                    cur_bits[d] = '0;
                    cur_nb[d]   = 0;
                end
                low_cnt[d]++;
                if (sclk[d] === 1'b1 && p_sclk[d] === 1'b0) begin
                    cur_bits[d] = {cur_bits[d][6:0], mosi[d]};
                    cur_nb[d]++;
                end
            end else begin
                if (p_cs[d] === 1'b0) begin
                    last_len[d]  = low_cnt[d];
                    last_bits[d] = cur_bits[d];
                    last_nb[d]   = cur_nb[d];
                    frames[d]++;
                end
                high_cnt[d]++;
            end
            p_sclk[d] = sclk[d];
            p_cs[d]   = cs_n[d];
            p_busy[d] = busy[d];
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input int d, input logic [3:0] v);
        if (d == 0) din0 = v; else din1 = v;
        start[d] = 1'b1;
        cyc(1);
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (done[d] !== 1'b1 && n < 300) begin
            cyc(1);
            n++;
        end
        if (done[d] !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL wait_done u%0d: done never rose within %0d cycles", d, n);
        end
    endtask

    task automatic check_idle_now(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s u%0d sclk", tag, d), {31'd0, sclk[d]}, 32'd0);
            chk($sformatf("%s u%0d mosi", tag, d), {31'd0, mosi[d]}, 32'd0);
            chk($sformatf("%s u%0d cs_n", tag, d), {31'd0, cs_n[d]}, 32'd1);
            chk($sformatf("%s u%0d busy", tag, d), {31'd0, busy[d]}, 32'd0);
            chk($sformatf("%s u%0d done", tag, d), {31'd0, done[d]}, 32'd0);
        end
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #7;
        rst = 1'b1;
        #1;
        check_idle_now(tag);
        cyc(2);
        rst = 1'b0;
    endtask

    // Expected serial words for the directed frames.
    function automatic logic [31:0] bits_of(input logic [3:0] d);
        return {24'd0, frame_of(d)};
    endfunction

    int d0, f0;

    initial begin
        rst   = 1'b1;
        start = 2'b00;
        din0  = 4'h0;
        din1  = 4'h0;
        #1;
        check_en = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(2);

        // Reset while idle
        async_reset("rst_idle");
        cyc(3);

        // Basic frame 4'hA on CLK_DIV=2
        send(0, 4'hA);
        wait_done(0);
        cyc(3);
`ifdef SPI_TX_PARITY_EN
        chk("frameA bits", {24'd0, last_bits[0]}, 32'h14);
`else
        chk("frameA bits", {24'd0, last_bits[0]}, 32'hA);
`endif
        chk("frameA nbits", last_nb[0], FB);
        chk("frameA cs_n low", last_len[0], 2 * (2 * FB + 2));
        chk("frameA busy len", last_busy[0], 2 * (2 * FB + 2) + 1);

        // Ignored starts mid-frame and in the DONE cycle
        d0 = dones[0];
        f0 = frames[0];
        send(0, 4'h3);
        cyc(6);
        send(0, 4'hF);
        wait_done(0);
        din0     = 4'hF;
        start[0] = 1'b1;
        cyc(1);
        start[0] = 1'b0;
        cyc(40);
        chk("ignore bits", {24'd0, last_bits[0]}, bits_of(4'h3));
        chk("ignore dones", dones[0] - d0, 1);
        chk("ignore frames", frames[0] - f0, 1);

        // Back-to-back frames
        send(0, 4'h0);
        wait_done(0);
        cyc(1);
        chk("b2b first bits", {24'd0, last_bits[0]}, bits_of(4'h0));
        send(0, 4'h9);
        wait_done(0);
        cyc(2);
        chk("b2b second bits", {24'd0, last_bits[0]}, bits_of(4'h9));
        chk("b2b gap>=1", {31'd0, (last_gap[0] >= 1)}, 32'd1);

        // CLK_DIV=1
        send(1, 4'h6);
        wait_done(1);
        cyc(2);
`ifdef SPI_TX_PARITY_EN
        chk("div1 bits", {24'd0, last_bits[1]}, 32'h0C);
`else
        chk("div1 bits", {24'd0, last_bits[1]}, 32'h6);
`endif
        chk("div1 cs_n low", last_len[1], 2 * FB + 2);

        // Parity-sensitive payloads
        send(0, 4'h7);
        wait_done(0);
        cyc(2);
`ifdef SPI_TX_PARITY_EN
        chk("frame7 bits", {24'd0, last_bits[0]}, 32'h0F);
`else
        chk("frame7 bits", {24'd0, last_bits[0]}, 32'h7);
`endif
        send(0, 4'h5);
        wait_done(0);
        cyc(2);
`ifdef SPI_TX_PARITY_EN
        chk("frame5 bits", {24'd0, last_bits[0]}, 32'h0A);
`else
        chk("frame5 bits", {24'd0, last_bits[0]}, 32'h5);
`endif

        // Reset mid-SHIFT: no done afterwards
        send(0, 4'hA);
        cyc(6);
        d0 = dones[0];
        async_reset("rst_shift");
        cyc(30);
        chk("no done after reset", dones[0] - d0, 0);

        // Randomized traffic on both instances
        for (int i = 0; i < 800; i++) begin
            start[0] = ($urandom_range(0, 5) == 0);
            start[1] = ($urandom_range(0, 5) == 0);
            din0     = 4'($urandom_range(0, 15));
            din1     = 4'($urandom_range(0, 15));
            cyc(1);
        end
        start = 2'b00;
        cyc(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_nibble_master_tx.md
Name: spi_nibble_master_tx

Overview:
- Transmit end of the board-to-board serial link that feeds the slave display board.
- Accepts a DATA_W-bit value (default one hex digit) on a start strobe.
- Shifts the value out MSB-first as SPI mode 0: CPOL=0, CPHA=0, with chip-select framing.
- The slave deserializes each frame and drives its 7-segment decoder, so this block sits on the master board between the control logic and the link pins.

Parameters:
- CLK_DIV, 4: system clocks per SCLK half-period; legal range >= 1.
- DATA_W, 4: payload bits per frame; legal range >= 1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- data_in  input  DATA_W  payload; captured on the cycle start is accepted.
- busy  output  1  high from the accept cycle until done drops.
- done  output  1  one-cycle pulse at frame end.
- sclk  output  1  serial clock; idles low.
- mosi  output  1  serial data, MSB first.
- cs_n  output  1  active-low frame select; idles high.

Behaviour:
- Reset, asynchronous and active-high: state=IDLE, sclk=0, mosi=0, cs_n=1, busy=0, done=0, shift register=0, counters=0.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE:
  - On the edge where start=1: latch data_in into the shift register, cs_n<=0, mosi<=data_in[DATA_W-1], busy<=1, go to SETUP.
  - start=0: outputs hold their idle values.
- SETUP: lasts CLK_DIV cycles with sclk=0, then go to SHIFT.
- SHIFT, per bit:
  - sclk=1 for CLK_DIV cycles; the slave samples mosi on the rising edge.
  - Then sclk=0 for CLK_DIV cycles.
  - mosi changes only on sclk's high-to-low transition, to the next bit.
  - After the low phase of the final bit, go to HOLD; mosi keeps the last bit.
- HOLD: CLK_DIV cycles with sclk=0 and cs_n=0.
- HOLD exit: cs_n<=1, mosi<=0, done<=1, go to DONE.
- DONE: one cycle; on exit done<=0, busy<=0, state=IDLE.
- Timing: cs_n is low for exactly CLK_DIV*(2*FRAME_BITS+2) cycles.
  - FRAME_BITS = DATA_W, or DATA_W+1 with the optional feature.
  - done rises on the same edge cs_n rises.
- start during any state other than IDLE: ignored, no queuing. Changes to data_in mid-frame have no effect.
- start in the DONE cycle: ignored; the earliest new accept is the cycle after DONE.
- Reset mid-frame: immediate return to reset values; no done pulse; the partial frame is abandoned (the slave discards it because cs_n rises).
- Half-period counter:
  - Width max(1,$clog2(CLK_DIV)).
  - Wraps at CLK_DIV-1 and is cleared on every state change.
- Bit counter: width $clog2(FRAME_BITS+1); counts 0..FRAME_BITS-1.

Optional Feature:
- Macro: SPI_TX_PARITY_EN.
- Defined:
  - FRAME_BITS = DATA_W+1.
  - An even-parity bit (XOR of the latched payload) is appended after the LSB.
  - The slave checks it.
- Undefined: FRAME_BITS = DATA_W; no parity logic is synthesized.
- All other timing rules apply with FRAME_BITS substituted.

Decomposition:
- Shared package spi_link_pkg:
  - state enum {IDLE, SETUP, SHIFT, HOLD, DONE}.
  - Default DATA_W constant, shared with the slave receiver so both ends agree on frame length.
  - Function frame_bits(DATA_W), which encapsulates the parity option.
- Sub-module sclk_tick_gen:
  - Parameterized by CLK_DIV.
  - Produces a one-cycle half_tick enable.
  - Has synchronous clear on state change.
  - The FSM consumes half_tick; no derived clocks.

Test Plan:
1. Reset: assert rst mid-idle and mid-SHIFT -> sclk=0, mosi=0, cs_n=1, busy=0, done=0 immediately (asynchronous), no done pulse afterwards.
2. Basic frame, CLK_DIV=2, DATA_W=4, data_in=4'hA with a one-cycle start -> cs_n low for 20 cycles; 4 sclk pulses, each 2 high / 2 low; mosi sampled at sclk rising edges = 1,0,1,0; done pulses on the cycle cs_n rises; busy high for 21 cycles.
3. Ignored start: send 4'h3, pulse start with data_in=4'hF mid-frame and again in the DONE cycle -> sampled bits = 0,0,1,1; exactly one done; no second frame.
4. Back-to-back frames: start 4'h0 and 4'h9, with the second start the cycle after DONE -> two frames with bits 0000 and 1001; cs_n high for at least one cycle between them.
5. CLK_DIV=1, data_in=4'h6 -> sclk toggles every cycle; cs_n low for 10 cycles; bits 0,1,1,0.
6. Parity, SPI_TX_PARITY_EN defined, CLK_DIV=2, data_in=4'h7 -> 5 sclk pulses with bits 0,1,1,1,1 (parity 1); cs_n low for 24 cycles; with data_in=4'h5 the parity bit is 0.
